// File: rtl/bus_pkg.sv
// Shared types and constants for the arbitrated datapath bus multiplexer.
// Source indices match the legacy select encoder codes.
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_ARB    = 1'b1;

  localparam int R0     = 0;
  localparam int R1     = 1;
  localparam int R2     = 2;
  localparam int R3     = 3;
  localparam int R4     = 4;
  localparam int R5     = 5;
  localparam int R6     = 6;
  localparam int R7     = 7;
  localparam int R8     = 8;
  localparam int R9     = 9;
  localparam int R10    = 10;
  localparam int R11    = 11;
  localparam int R12    = 12;
  localparam int R13    = 13;
  localparam int R14    = 14;
  localparam int R15    = 15;
  localparam int HI     = 16;
  localparam int LO     = 17;
  localparam int Y      = 18;
  localparam int ZHI    = 19;
  localparam int ZLO    = 20;
  localparam int PC     = 21;
  localparam int MDR    = 22;
  localparam int INPORT = 23;
  localparam int CSIGN  = 24;

endpackage

// File: rtl/bus_arbiter_mux_rr_arbiter.sv
// Combinational round-robin picker: first request at or after rr_ptr+1
// (wrapping), ignoring sources set in the exclude mask.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_SRC = 25,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] i_req,
  input  logic [SEL_W-1:0]   i_rr_ptr,
  input  logic [NUM_SRC-1:0] i_excl,
  output logic [SEL_W-1:0]   o_winner,
  output logic               o_any_req
);

  logic [NUM_SRC-1:0] w_masked;
  logic [SEL_W-1:0]   w_cand [NUM_SRC];
  logic [NUM_SRC-1:0] w_hit;

  assign w_masked  = i_req & ~i_excl;
  assign o_any_req = |w_masked;

  // w_cand[k] is the source visited k+1 steps after the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      assign w_cand[gi] = SEL_W'((int'(i_rr_ptr) + 1 + gi) % NUM_SRC);
      assign w_hit[gi]  = w_masked[w_cand[gi]];
    end
  endgenerate

  always_comb begin
    o_winner = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        o_winner = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_mux.sv
// Registered shared-bus multiplexer with legacy direct select and a
// round-robin arbitrated mode featuring bounded ownership and bus lock.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_SRC  = 25,
  parameter int SEL_W    = $clog2(NUM_SRC),
  parameter int MAX_HOLD = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_req,
  input  logic [NUM_SRC-1:0]       src_lock,
  output logic [NUM_SRC-1:0]       grant,
  output logic [SEL_W-1:0]         owner,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic                     sel_err
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [NUM_SRC-1:0] ONE_HOT0 = NUM_SRC'(1);
  localparam logic [SEL_W-1:0] RR_RESET = SEL_W'(NUM_SRC - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [SEL_W-1:0]   r_owner;
  logic [SEL_W-1:0]   w_owner_next;
  logic [HOLD_W-1:0]  r_hold;
  logic [HOLD_W-1:0]  w_hold_next;
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [SEL_W-1:0]   w_rr_next;
  logic [NUM_SRC-1:0] r_grant;
  logic [NUM_SRC-1:0] w_grant_next;
  logic [WIDTH-1:0]   r_bus;
  logic [WIDTH-1:0]   w_bus_next;
  logic               r_valid;
  logic               w_valid_next;
  logic               r_sel_err;
  logic               w_sel_err_next;

  logic [WIDTH-1:0]   w_src [NUM_SRC];
  logic [NUM_SRC-1:0] w_excl;
  logic [SEL_W-1:0]   w_winner;
  logic               w_any;
  logic               w_owner_req;
  logic               w_owner_lock;
  logic               w_sel_ok;
  logic               w_hold_max;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign w_src[gi] = src_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // While owning, the arbiter only looks at competitors of the owner.
  assign w_excl       = (r_state == OWN) ? (ONE_HOT0 << r_owner) : '0;
  assign w_owner_req  = src_req[r_owner];
  assign w_owner_lock = src_lock[r_owner];
  assign w_sel_ok     = int'(sel) < NUM_SRC;
  assign w_hold_max   = (r_hold == HOLD_LAST);

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .SEL_W   (SEL_W)
  ) u_rr_arbiter (
    .i_req     (src_req),
    .i_rr_ptr  (r_rr_ptr),
    .i_excl    (w_excl),
    .o_winner  (w_winner),
    .o_any_req (w_any)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_hold    <= '0;
      r_rr_ptr  <= RR_RESET;
      r_grant   <= '0;
      r_bus     <= '0;
      r_valid   <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_owner   <= w_owner_next;
      r_hold    <= w_hold_next;
      r_rr_ptr  <= w_rr_next;
      r_grant   <= w_grant_next;
      r_bus     <= w_bus_next;
      r_valid   <= w_valid_next;
      r_sel_err <= w_sel_err_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_hold_next  = r_hold;
    w_rr_next    = r_rr_ptr;
    if (mode == MODE_DIRECT) begin
      w_state_next = IDLE;
      w_hold_next  = '0;
      w_owner_next = w_sel_ok ? sel : '0;
    end else if (r_state == IDLE) begin
      w_owner_next = '0;
      w_hold_next  = '0;
      if (w_any) begin
        w_state_next = OWN;
        w_owner_next = w_winner;
        w_rr_next    = w_winner;
      end
    end else begin
      if (!w_owner_req && !w_any) begin
        w_state_next = IDLE;
        w_owner_next = '0;
        w_hold_next  = '0;
      end else if (!w_owner_req || (!w_owner_lock && w_any && w_hold_max)) begin
        w_owner_next = w_winner;
        w_rr_next    = w_winner;
        w_hold_next  = '0;
      end else if (!w_any) begin
        w_hold_next = '0;
      end else if (!w_hold_max) begin
        // A locked owner also counts up, saturating at the last hold cycle.
        w_hold_next = r_hold + 1'b1;
      end
    end
  end

  always_comb begin
    w_valid_next   = (mode == MODE_DIRECT) ? w_sel_ok : (w_state_next == OWN);
    w_sel_err_next = (mode == MODE_DIRECT) && !w_sel_ok;
    w_grant_next   = w_valid_next ? (ONE_HOT0 << w_owner_next) : '0;
    w_bus_next     = w_valid_next ? w_src[w_owner_next] : '0;
  end

  assign grant     = r_grant;
  assign owner     = r_owner;
  assign bus_out   = r_bus;
  assign bus_valid = r_valid;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model of the bus owner.
module tb_bus_arbiter_mux;
  import bus_pkg::*;

  localparam int WIDTH    = 32;
  localparam int NUM_SRC  = 25;
  localparam int SEL_W    = 5;
  localparam int MAX_HOLD = 4;

  logic                     clock = 1'b0;
  logic                     clear;
  logic                     mode;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_req;
  logic [NUM_SRC-1:0]       src_lock;
  logic [NUM_SRC-1:0]       grant;
  logic [SEL_W-1:0]         owner;
  logic [WIDTH-1:0]         bus_out;
  logic                     bus_valid;
  logic                     sel_err;

  logic [WIDTH-1:0] data [NUM_SRC];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  bit               m_busy;
  int               m_owner;
  int               m_hold;
  int               m_ptr;
  logic [WIDTH-1:0] m_bus;
  bit               m_valid;
  bit               m_err;
  logic [NUM_SRC-1:0] m_grant;

  bus_arbiter_mux #(
    .WIDTH    (WIDTH),
    .NUM_SRC  (NUM_SRC),
    .SEL_W    (SEL_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clock     (clock),
    .clear     (clear),
    .mode      (mode),
    .sel       (sel),
    .src_data  (src_data),
    .src_req   (src_req),
    .src_lock  (src_lock),
    .grant     (grant),
    .owner     (owner),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .sel_err   (sel_err)
  );

  always #5 clock = ~clock;

  always_comb begin
    src_data = '0;
    for (int i = 0; i < NUM_SRC; i++) src_data[i*WIDTH +: WIDTH] = data[i];
  end

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [NUM_SRC-1:0] r, int start);
    for (int k = 1; k <= NUM_SRC; k++) begin
      int i;
      i = (start + k) % NUM_SRC;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_hold = 0; m_ptr = NUM_SRC - 1;
    m_bus = '0; m_valid = 0; m_err = 0; m_grant = '0;
  endtask

  task automatic hand_to(logic [NUM_SRC-1:0] cands);
    m_owner = pick(cands, m_ptr);
    m_ptr   = m_owner;
    m_hold  = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present at the edge.
  task automatic model_step();
    logic [NUM_SRC-1:0] others;
    if (mode == 1'b0) begin
      m_busy = 0;
      m_hold = 0;
      m_err  = (int'(sel) >= NUM_SRC);
      m_valid = !m_err;
      m_owner = m_err ? 0 : int'(sel);
      m_bus   = m_err ? '0 : data[sel];
    end else begin
      m_err  = 0;
      others = src_req;
      if (m_busy) others[m_owner] = 1'b0;
      if (!m_busy) begin
        m_owner = 0;
        m_hold  = 0;
        if (src_req != 0) begin
          hand_to(src_req);
          m_busy = 1;
        end
      end else if (!src_req[m_owner]) begin
        if (others == 0) begin
          m_busy = 0; m_owner = 0; m_hold = 0;
        end else begin
          hand_to(others);
        end
      end else if (src_lock[m_owner]) begin
        m_hold = (others == 0) ? 0 : ((m_hold + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_hold + 1);
      end else if (others != 0 && m_hold == MAX_HOLD - 1) begin
        hand_to(others);
      end else begin
        m_hold = (others != 0) ? m_hold + 1 : 0;
      end
      m_valid = m_busy;
      m_bus   = m_busy ? data[m_owner] : '0;
    end
    m_grant = m_valid ? (NUM_SRC'(1) << m_owner) : '0;
  endtask

  task automatic check_all(string tag);
    check_eq({tag, ".grant"}, 64'(grant), 64'(m_grant));
    check_eq({tag, ".owner"}, 64'(owner), 64'(m_owner));
    check_eq({tag, ".bus"}, 64'(bus_out), 64'(m_bus));
    check_eq({tag, ".valid"}, 64'(bus_valid), 64'(m_valid));
    check_eq({tag, ".sel_err"}, 64'(sel_err), 64'(m_err));
  endtask

  task automatic tick(string tag);
    @(posedge clock);
    if (clear) model_reset();
    else model_step();
    #1;
    check_all(tag);
    $display("%s: mode=%0b req=%h lock=%h owner=%0d valid=%0b bus=%h err=%0b",
             tag, mode, src_req, src_lock, owner, bus_valid, bus_out, sel_err);
  endtask

  initial begin
    for (int i = 0; i < NUM_SRC; i++) data[i] = $urandom;
    clear = 1'b1; mode = MODE_DIRECT; sel = '0; src_req = '0; src_lock = '0;
    model_reset();
    #2;
    check_eq("reset.grant", 64'(grant), 64'd0);
    check_eq("reset.valid", 64'(bus_valid), 64'd0);
    check_eq("reset.bus", 64'(bus_out), 64'd0);
    tick("reset");
    clear = 1'b0;

    // Direct select of MDR
    sel = SEL_W'(MDR);
    data[MDR] = 32'hDEADBEEF;
    tick("direct");
    check_eq("direct.bus_const", 64'(bus_out), 64'hDEADBEEF);
    check_eq("direct.owner_const", 64'(owner), 64'd22);
    check_eq("direct.grant22", 64'(grant[22]), 64'd1);

    // Out-of-range select, then sel_err must drop
    sel = 5'd30;
    tick("oor");
    check_eq("oor.err_const", 64'(sel_err), 64'd1);
    sel = 5'd0;
    tick("oor_after");
    check_eq("oor.err_pulse", 64'(sel_err), 64'd0);

    // Round robin between R3 and R7
    mode = MODE_ARB;
    src_req = '0;
    src_req[R3] = 1'b1;
    src_req[R7] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick("rr");
      check_eq("rr.owner_seq", 64'(owner), ((k / MAX_HOLD) % 2 == 0) ? 64'd3 : 64'd7);
      data[$urandom_range(0, NUM_SRC - 1)] = $urandom;
    end
    src_req = '0;
    tick("rr_idle");

    // Lock by R5 against pending R9
    src_req[R5] = 1'b1;
    tick("lock_get");
    check_eq("lock.owner5", 64'(owner), 64'd5);
    src_lock[R5] = 1'b1;
    src_req[R9] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick("lock_hold");
      check_eq("lock.keep5", 64'(owner), 64'd5);
    end
    src_lock = '0;
    tick("lock_drop");
    check_eq("lock.to9", 64'(owner), 64'd9);

    // Release without bubble, then idle
    src_req = '0;
    src_req[R2] = 1'b1;
    tick("rel_get2");
    src_req[R12] = 1'b1;
    tick("rel_both");
    src_req[R2] = 1'b0;
    tick("rel_hand");
    check_eq("rel.owner12", 64'(owner), 64'd12);
    check_eq("rel.no_bubble", 64'(bus_valid), 64'd1);
    src_req = '0;
    tick("rel_idle");
    check_eq("rel.idle_valid", 64'(bus_valid), 64'd0);
    check_eq("rel.idle_bus", 64'(bus_out), 64'd0);

    // Asynchronous clear while R7 owns the bus
    src_req[R7] = 1'b1;
    tick("clr_get7");
    clear = 1'b1;
    #1;
    check_eq("clr.async_grant", 64'(grant), 64'd0);
    check_eq("clr.async_valid", 64'(bus_valid), 64'd0);
    model_reset();
    tick("clr_hold");
    clear = 1'b0;
    src_req = '0;
    src_req[R0] = 1'b1;
    src_req[R7] = 1'b1;
    tick("clr_release");
    check_eq("clr.owner0", 64'(owner), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0)
        src_req = NUM_SRC'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 2) == 0)
        src_lock = NUM_SRC'($urandom & $urandom);
      else if ($urandom_range(0, 2) == 0)
        src_lock = '0;
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      else if (mode == MODE_DIRECT && $urandom_range(0, 3) == 0) mode = MODE_ARB;
      sel = SEL_W'($urandom_range(0, 31));
      data[$urandom_range(0, NUM_SRC - 1)] = $urandom;
      data[$urandom_range(0, NUM_SRC - 1)] = $urandom;
      if (clear) clear = 1'b0;
      else if ($urandom_range(0, 99) == 0) clear = 1'b1;
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Parametrised, registered successor to the datapath bus multiplexer. It adds request/grant arbitration among NUM_SRC sources, a bounded ownership time and a bus-lock facility.
- A legacy direct-select mode keeps the existing control-unit sequencing, where the encoder drives a select code, working unchanged.
- Sits between register file, special registers (HI/LO/Y/Z/PC/MDR/InPort/C) and the shared bus.

Parameters:
- WIDTH, 32, data width of each source and of the bus
- NUM_SRC, 25, number of bus sources (index 0..NUM_SRC-1)
- SEL_W, $clog2(NUM_SRC), width of select and owner codes
- MAX_HOLD, 4, maximum consecutive cycles one unlocked owner keeps the bus while others request (>=1)

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-high reset
- mode  in  1  0 = direct select, 1 = arbitrated
- sel  in  SEL_W  source code, used in direct mode only
- src_data  in  NUM_SRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH]
- src_req  in  NUM_SRC  per-source bus request (arbitrated mode)
- src_lock  in  NUM_SRC  per-source lock; effective only for the current owner
- grant  out  NUM_SRC  one-hot registered grant, all-zero when bus idle
- owner  out  SEL_W  index of the current driver, 0 when idle
- bus_out  out  WIDTH  registered bus value
- bus_valid  out  1  bus_out carries a granted source's data
- sel_err  out  1  one-cycle pulse: direct-mode sel >= NUM_SRC

Behaviour:
- Clock and reset: one clock, `clock`. Reset `clear` is asynchronous and active-high.
- While clear is high:
  - grant = 0, owner = 0, bus_out = 0, bus_valid = 0, sel_err = 0.
  - state = IDLE, hold_cnt = 0.
  - rr_ptr = NUM_SRC-1, so source 0 has first priority.
  - Clear asserted mid-ownership drops the grant immediately; no drain.
- Latency: all outputs are registered. A decision made from inputs sampled at edge t appears after edge t. bus_out then holds src_data of the new owner as sampled at edge t.
- Direct mode (mode=0), every edge:
  - sel < NUM_SRC: bus_out <= src_data[sel]; owner <= sel; grant <= one-hot(sel); bus_valid <= 1; sel_err <= 0.
  - sel >= NUM_SRC: bus_out <= 0; grant <= 0; owner <= 0; bus_valid <= 0; sel_err <= 1.
  - state forced to IDLE, hold_cnt <= 0. src_req/src_lock are ignored. rr_ptr is unchanged.
- Arbitrated mode (mode=1) uses two states, IDLE and OWN.
  - Round-robin pick: the first set src_req index scanning from rr_ptr+1 upward, wrapping NUM_SRC-1 -> 0. On every new grant, rr_ptr <= the winner.
  - IDLE, no request: outputs stay zero.
  - IDLE, any request: go to OWN with the winner granted; bus_valid <= 1; hold_cnt <= 0.
  - OWN: each edge bus_out <= src_data[owner]. Transitions are evaluated in priority order:
    1. Owner's req low and no other request: go to IDLE; grant/bus_out/bus_valid <= 0.
    2. Owner's req low and another request pending: hand over directly to the round-robin winner, with no idle bubble.
    3. Owner's lock high: keep the owner; hold_cnt saturates at MAX_HOLD-1.
    4. Another request pending and hold_cnt == MAX_HOLD-1: hand over to the round-robin winner, which excludes the owner.
    5. Otherwise: keep the owner; hold_cnt increments only while another request is pending, else holds at 0.
  - Lock from a non-owner is ignored.
  - A handover resets hold_cnt to 0.
- Mode switch: takes effect at the next edge. Arbitrated -> direct drops any ownership and lock. Direct -> arbitrated starts from IDLE.
- sel_err is asserted only in direct mode.

Decomposition:
- Shared package bus_pkg:
  - state enum {IDLE, OWN};
  - MODE_DIRECT/MODE_ARB constants;
  - source-index constants (R0..R15 = 0..15, HI=16, LO=17, Y=18, ZHI=19, ZLO=20, PC=21, MDR=22, INPORT=23, CSIGN=24).
- One sub-module: rr_arbiter. It is combinational; inputs are req vector, rr_ptr and an exclude mask. Outputs are winner index and any_req.
- FSM, counter and output registers live in bus_arbiter_mux.

Test Plan:
- Reset/direct: clear pulse -> all outputs 0. Then mode=0, sel=22, src_data[22]=32'hDEADBEEF -> after one edge bus_out=DEADBEEF, grant[22]=1, owner=22, bus_valid=1.
- Out of range: sel=30 -> bus_out=0, bus_valid=0, grant=0, sel_err high exactly one cycle.
- Round robin: mode=1, src_req bits 3 and 7 held continuously, no locks, MAX_HOLD=4 -> owner 3 for 4 cycles, 7 for 4, 3 for 4. bus_out tracks the owner's data.
- Lock: owner 5 with src_lock[5]=1 and req 9 pending for 10 cycles -> owner stays 5. Lock drops -> 9 granted on the next edge.
- Release: owner 2 drops req while req 12 pending -> next edge owner=12, bus_valid stays 1 (no bubble). 12 drops with none pending -> IDLE, bus_valid=0, bus_out=0.
- Async clear mid-OWN (owner 7) -> grant/bus_valid go 0 without a clock edge. After release with req 0 and 7 set -> owner=0 (rr_ptr reset).
